// File: rtl/mem_sram_ctrl.sv
// mem_sram_ctrl: memory-stage controller that splits each 32-bit word load or
// store into two half-word accesses on a 16-bit external SRAM. It holds
// `ready` low to freeze the pipeline until the access finishes.
module mem_sram_ctrl #(
    parameter int BASE_ADDR     = 1024,
    parameter int ACCESS_CYCLES = 5     // accept cycle to ready pulse, legal range 3..15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    output logic [17:0] sram_addr,
    output logic [15:0] sram_dq_out,
    input  logic [15:0] sram_dq_in,
    output logic        sram_dq_oe,
    output logic        sram_we_n
);

    typedef enum logic [2:0] {IDLE, LOW, HIGH, WAIT, DONE} state_t;

    // Transaction latched at accept. Later changes on the inputs do not affect it.
    typedef struct packed {
        logic        is_wr;
        logic [16:0] word;
        logic [31:0] wdata;
    } req_t;

    localparam logic [3:0] LAST_CNT = 4'(ACCESS_CYCLES - 1);

    state_t     state, state_nxt;
    logic [3:0] cnt, cnt_nxt;
    req_t       req;
    logic       accept;

    assign accept = (state == IDLE) && (rd_en || wr_en);

    // State, counter and request latch. A reset aborts any access in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            req   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) begin
                // A store takes priority when both requests are high. Address bits [1:0] drop out in the shift.
                req.is_wr <= wr_en;
                req.word  <= 17'((address - 32'(BASE_ADDR)) >> 2);
                req.wdata <= write_data;
            end
        end
    end

    // Load capture: each half is sampled at the end of its SRAM cycle. The value holds between loads.
    always_ff @(posedge clk) begin
        if (rst) begin
            read_data <= '0;
        end else if (!req.is_wr) begin
            if (state == LOW)  read_data[15:0]  <= sram_dq_in;
            if (state == HIGH) read_data[31:16] <= sram_dq_in;
        end
    end

    // Next-state, counter and SRAM/pipeline outputs. The bus is released outside the LOW/HIGH states of a store.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        ready       = 1'b0;
        sram_addr   = '0;
        sram_dq_out = '0;
        sram_dq_oe  = 1'b0;
        sram_we_n   = 1'b1;
        case (state)
            IDLE: begin
                ready = ~(rd_en | wr_en);
                if (accept) begin
                    state_nxt = LOW;
                    cnt_nxt   = 4'd1;
                end
            end
            LOW: begin
                sram_addr = {req.word, 1'b0};
                if (req.is_wr) begin
                    sram_dq_out = req.wdata[15:0];
                    sram_dq_oe  = 1'b1;
                    sram_we_n   = 1'b0;
                end
                state_nxt = HIGH;
                cnt_nxt   = cnt + 4'd1;
            end
            HIGH: begin
                sram_addr = {req.word, 1'b1};
                if (req.is_wr) begin
                    sram_dq_out = req.wdata[31:16];
                    sram_dq_oe  = 1'b1;
                    sram_we_n   = 1'b0;
                end
                // With the shortest access time there is no WAIT state.
                state_nxt = (cnt == LAST_CNT) ? DONE : WAIT;
                cnt_nxt   = cnt + 4'd1;
            end
            WAIT: begin
                cnt_nxt = cnt + 4'd1;
                if (cnt == LAST_CNT) state_nxt = DONE;
            end
            DONE: begin
                ready     = 1'b1;
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

endmodule
